// File: rtl/sample_gain.sv
// sample_gain: DAC sample-rate strobe plus gain-ramped scaling of the tone_gen sample.
// One sample is captured per strobe and multiplied serially, LSB first, by the current gain.
// The result is presented in offset-binary form with a one-cycle valid that starts the SPI transfer.
module sample_gain #(
  parameter int unsigned IN_BITS  = 18,
  parameter int unsigned OUT_BITS = 16,
  parameter int unsigned G_BITS   = 8,
  parameter int unsigned DIV      = 1042
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_BITS-1:0]  in,
  input  logic [G_BITS-1:0]   gain,
  output logic [OUT_BITS-1:0] out,
  output logic                out_valid
);

  localparam int unsigned AccBits = IN_BITS + G_BITS;
  localparam int unsigned CntBits = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IdxBits = $clog2(G_BITS + 1);

  typedef enum logic [1:0] {StIdle, StMul, StOut} state_e;

  state_e                     state_q;
  logic [CntBits-1:0]         div_cnt_q;
  logic [G_BITS-1:0]          gain_cur_q;
  logic [G_BITS-1:0]          mult_q;
  logic [IdxBits-1:0]         idx_q;
  logic signed [IN_BITS-1:0]  s_q;
  logic signed [AccBits-1:0]  acc_q;

  logic                       tick;
  logic [G_BITS-1:0]          gain_next;
  logic signed [IN_BITS-1:0]  s_in;
  logic signed [AccBits-1:0]  s_ext;
  logic signed [AccBits-1:0]  addend;
  logic [OUT_BITS-1:0]        out_next;

  // Strobe decode, gain ramp step, operand conditioning and output formatting.
  always_comb begin
    tick      = (div_cnt_q == CntBits'(DIV - 1));
    gain_next = gain_cur_q;
    if (gain > gain_cur_q) begin
      gain_next = gain_cur_q + G_BITS'(1);
    end else if (gain < gain_cur_q) begin
      gain_next = gain_cur_q - G_BITS'(1);
    end
    // Offset-binary to two's complement: flip the MSB.
    s_in   = {~in[IN_BITS-1], in[IN_BITS-2:0]};
    s_ext  = {{G_BITS{s_q[IN_BITS-1]}}, s_q};
    addend = s_ext <<< idx_q;
    // acc >>> G_BITS keeps the top IN_BITS bits of acc; the product is exact and fits AccBits,
    // so taking the top OUT_BITS bits directly is the floor-truncated result.
    out_next = {~acc_q[AccBits-1], acc_q[AccBits-2:AccBits-OUT_BITS]};
  end

  // Sample-rate prescaler: counts 0..DIV-1 and wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + CntBits'(1);
    end
  end

  // Capture / serial shift-add multiply / output FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      gain_cur_q <= '0;
      mult_q     <= '0;
      idx_q      <= '0;
      s_q        <= '0;
      acc_q      <= '0;
      out        <= {1'b1, {(OUT_BITS-1){1'b0}}};
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            s_q        <= s_in;
            gain_cur_q <= gain_next;
            mult_q     <= gain_next;
            acc_q      <= '0;
            idx_q      <= '0;
            state_q    <= StMul;
          end
        end
        StMul: begin
          // mult_q is shifted down so bit 0 is always the current multiplier bit.
          if (mult_q[0]) begin
            acc_q <= acc_q + addend;
          end
          mult_q <= mult_q >> 1;
          idx_q  <= idx_q + IdxBits'(1);
          if (idx_q == IdxBits'(G_BITS - 1)) begin
            state_q <= StOut;
          end
        end
        StOut: begin
          out       <= out_next;
          out_valid <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_gain.sv
// Bench for sample_gain: a fast instance (DIV=16) carries the value scoreboard over full gain
// ramps, a default instance (DIV=1042) is watched for strobe timing only.
module tb_sample_gain;

  localparam int unsigned DivF = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        released = 1'b0;
  logic [17:0] in_s;
  logic [7:0]  gain_s;
  logic [15:0] out_f, out_s;
  logic        v_f, v_s;

  always #5 clk = ~clk;

  sample_gain #(.DIV(DivF)) u_fast (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in_s),
    .gain     (gain_s),
    .out      (out_f),
    .out_valid(v_f)
  );

  sample_gain u_slow (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (in_s),
    .gain     (gain_s),
    .out      (out_s),
    .out_valid(v_s)
  );

  int          total = 0;
  int          bad = 0;
  int          n_seen = 0;
  bit          slow_done = 1'b0;
  logic        prev_v = 1'b0;
  logic [15:0] expq[$];
  logic [15:0] exp_cur;

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Reference: offset-binary to signed, exact multiply, floor shift, back to offset-binary.
  function automatic logic [15:0] model(input logic [17:0] x, input int g);
    longint s, p, y;
    logic [17:0] y18;
    s   = longint'(x) - 64'sd131072;
    p   = s * longint'(g);
    y   = p >>> 8;
    y18 = y[17:0];
    return {~y18[17], y18[16:2]};
  endfunction

  // Monitor: every fast out_valid pops one expectation.
  always @(negedge clk) begin
    if (v_f === 1'b1) begin
      check("valid_width", longint'(prev_v), 0);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got out=0x%0h expected no pulse", out_f);
      end else begin
        exp_cur = expq.pop_front();
        check("out", longint'(out_f), longint'(exp_cur));
      end
      n_seen++;
    end
    prev_v <= v_f;
  end

  // Waits for the next fast sample, counting negedges; 'already' counts edges spent by caller.
  task automatic wait_sample(input int exp_edges, input int already);
    int start;
    int e;
    start = n_seen;
    e = already;
    while (n_seen == start && e < 3 * DivF + 40) begin
      @(negedge clk);
      #1;
      e++;
    end
    check("gap_fast", longint'(e), longint'(exp_edges));
  endtask

  // Default instance: tick falls in cycle DIV-1 after release, valid 10 cycles later (1051),
  // then every 1042 cycles.
  initial begin
    int cnt;
    int last;
    int e;
    cnt = 0;
    last = 0;
    wait (released);
    for (int p = 0; p < 3; p++) begin
      e = 0;
      while (1) begin
        @(negedge clk);
        cnt++;
        e++;
        if (v_s === 1'b1 || e > 3000) break;
      end
      check("gap_slow", longint'(cnt - last), (p == 0) ? 1051 : 1042);
      last = cnt;
    end
    slow_done = 1'b1;
  end

  initial begin
    logic [17:0] vec[4];
    int g;
    int w;
    vec[0] = 18'h20000;
    vec[1] = 18'h12345;
    vec[2] = 18'h2ABCD;
    vec[3] = 18'h00000;

    reset_n = 1'b1;
    in_s    = 18'h3FFFF;
    gain_s  = 8'hFF;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_fast", longint'(out_f), 16'h8000);
    check("rst_valid_fast", longint'(v_f), 0);
    check("rst_out_slow", longint'(out_s), 16'h8000);
    check("rst_valid_slow", longint'(v_s), 0);

    // Ramp up from reset: first sample uses gain_cur=1 (in full-scale -> 0x807F).
    expq.push_back(16'h807F);
    reset_n  = 1'b1;
    released = 1'b1;
    wait_sample(DivF + 9, 0);
    for (int k = 2; k <= 255; k++) begin
      in_s = vec[k % 4];
      expq.push_back(model(in_s, k));
      wait_sample(DivF, 0);
    end

    // gain_cur held at 255, no wrap.
    in_s = 18'h3FFFF; expq.push_back(16'hFF7F); wait_sample(DivF, 0);
    in_s = 18'h20000; expq.push_back(16'h8000); wait_sample(DivF, 0);
    in_s = 18'h00000; expq.push_back(16'h0080); wait_sample(DivF, 0);

    // Inputs changed mid-multiply must not affect the sample in flight.
    in_s = 18'h3FFFF;
    expq.push_back(16'hFF7F);
    repeat (9) @(negedge clk);
    #1;
    in_s   = 18'h00000;
    gain_s = 8'h00;
    wait_sample(DivF, 9);
    gain_s = 8'hFF;
    in_s = 18'h20000; expq.push_back(16'h8000); wait_sample(DivF, 0);

    // Ramp down 255 -> 0, one LSB per sample, then hold at 0.
    gain_s = 8'h00;
    for (int j = 1; j <= 256; j++) begin
      g = (j < 255) ? 255 - j : 0;
      if (j == 127) begin
        in_s = 18'h00000; expq.push_back(16'h4000);
      end else if (j == 254) begin
        in_s = 18'h3FFFF; expq.push_back(16'h807F);
      end else if (j == 255) begin
        in_s = 18'h3FFFF; expq.push_back(16'h8000);
      end else if (j == 256) begin
        in_s = 18'h00000; expq.push_back(16'h8000);
      end else begin
        in_s = vec[j % 4];
        expq.push_back(model(in_s, g));
      end
      wait_sample(DivF, 0);
    end

    // Reset during multiply cycle 3: aborted sample never appears.
    in_s = 18'h3FFFF;
    repeat (10) @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_out", longint'(out_f), 16'h8000);
    check("midrst_valid", longint'(v_f), 0);
    repeat (3) @(negedge clk);
    #1;
    check("midrst_out_hold", longint'(out_f), 16'h8000);
    gain_s = 8'd200;
    in_s   = 18'h00000;
    expq.push_back(16'h7F80);
    reset_n = 1'b1;
    wait_sample(DivF + 9, 0);

    w = 0;
    while (!slow_done && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check("slow_checker_done", longint'(slow_done), 1);
    check("queue_drained", longint'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
